// File: rtl/multicycle_control.sv
// Multi-cycle CPU control FSM: sequences fetch/decode/execute/memory/writeback
// over several clocks, stalls on mem_ready, counts retired instructions and
// traps unsupported opcodes in a sticky ILLEGAL state.
module multicycle_control #(
  parameter int MEM_WAIT_MAX = 15,
  parameter int CNT_W        = 32
) (
  input  logic             clk_cpu,
  input  logic             reset,
  input  logic [5:0]       opcode,
  input  logic [5:0]       func,
  input  logic             mem_ready,
  output logic             pc_write,
  output logic             pc_write_beq,
  output logic             pc_write_bne,
  output logic [1:0]       pc_src,
  output logic             iord,
  output logic             mem_read,
  output logic             mem_write,
  output logic             ir_write,
  output logic             reg_write,
  output logic [1:0]       reg_dst,
  output logic [1:0]       mem2reg,
  output logic             alu_src_a,
  output logic [2:0]       alu_src_b,
  output logic [2:0]       alu_control,
  output logic             illegal,
  output logic             mem_timeout,
  output logic [3:0]       state,
  output logic [CNT_W-1:0] inst_count
);

  typedef enum logic [3:0] {
    FETCH    = 4'd0,  DECODE = 4'd1,  MEM_ADDR = 4'd2,  MEM_RD = 4'd3,
    MEM_WB   = 4'd4,  MEM_WR = 4'd5,  R_EXEC   = 4'd6,  R_WB   = 4'd7,
    BRANCH   = 4'd8,  JUMP   = 4'd9,  I_EXEC   = 4'd10, I_WB   = 4'd11,
    ST_ILLEGAL = 4'd12
  } state_t;

  localparam logic [5:0] OP_R = 6'b000000, OP_LW = 6'b100011, OP_SW = 6'b101011,
                         OP_BEQ = 6'b000100, OP_BNE = 6'b000101, OP_ADDI = 6'b001000,
                         OP_ANDI = 6'b001100, OP_ORI = 6'b001101, OP_SLTI = 6'b001010,
                         OP_LUI = 6'b001111, OP_J = 6'b000010, OP_JAL = 6'b000011;
  localparam logic [5:0] FN_JR = 6'b001000;

  localparam logic [2:0] ALU_AND = 3'b000, ALU_OR = 3'b001, ALU_ADD = 3'b010,
                         ALU_SUB = 3'b110, ALU_SLT = 3'b111, ALU_NOR = 3'b100,
                         ALU_SRL = 3'b101, ALU_XOR = 3'b011;

  localparam int SW_W = $clog2(MEM_WAIT_MAX + 1);
  localparam logic [SW_W-1:0] STALL_MAX = SW_W'(MEM_WAIT_MAX);

  state_t          cur, nxt;
  logic            r_ok, i_ok;
  logic [2:0]      r_alu, i_alu, i_asb;
  logic [SW_W-1:0] stall, stall_inc;
  logic            waiting, retire;

  assign state = cur;

  // Instruction decode: legal R-type funcs, ALU op for R/I forms, I-type B select
  always_comb begin
    r_ok  = 1'b1;
    r_alu = 3'b000;
    case (func)
      6'b100000: r_alu = ALU_ADD;
      6'b100010: r_alu = ALU_SUB;
      6'b100100: r_alu = ALU_AND;
      6'b100101: r_alu = ALU_OR;
      6'b100111: r_alu = ALU_NOR;
      6'b100110: r_alu = ALU_XOR;
      6'b101010: r_alu = ALU_SLT;
      6'b000010: r_alu = ALU_SRL;
      default:   r_ok  = 1'b0;
    endcase
    i_ok  = 1'b1;
    i_alu = 3'b000;
    i_asb = 3'b000;
    case (opcode)
      OP_ADDI: begin i_asb = 3'b010; i_alu = ALU_ADD; end
      OP_SLTI: begin i_asb = 3'b010; i_alu = ALU_SLT; end
      OP_ANDI: begin i_asb = 3'b100; i_alu = ALU_AND; end
      OP_ORI:  begin i_asb = 3'b100; i_alu = ALU_OR;  end
      OP_LUI:  begin i_asb = 3'b101; i_alu = ALU_OR;  end
      default: i_ok = 1'b0;
    endcase
  end

  // State register
  always_ff @(posedge clk_cpu) begin
    if (reset) cur <= FETCH;
    else       cur <= nxt;
  end

  // Next state and per-state datapath controls; strobes gated off during reset
  always_comb begin
    nxt          = cur;
    pc_write     = 1'b0;
    pc_write_beq = 1'b0;
    pc_write_bne = 1'b0;
    pc_src       = 2'b00;
    iord         = 1'b0;
    mem_read     = 1'b0;
    mem_write    = 1'b0;
    ir_write     = 1'b0;
    reg_write    = 1'b0;
    reg_dst      = 2'b00;
    mem2reg      = 2'b00;
    alu_src_a    = 1'b0;
    alu_src_b    = 3'b000;
    alu_control  = 3'b000;
    illegal      = 1'b0;
    case (cur)
      FETCH: begin
        mem_read    = 1'b1;
        alu_src_b   = 3'b001;
        alu_control = ALU_ADD;
        ir_write    = mem_ready;
        pc_write    = mem_ready;
        if (mem_ready) nxt = DECODE;
      end
      DECODE: begin
        alu_src_b   = 3'b011;
        alu_control = ALU_ADD;
        if (opcode == OP_LW || opcode == OP_SW)               nxt = MEM_ADDR;
        else if (opcode == OP_R && func == FN_JR)             nxt = JUMP;
        else if (opcode == OP_R)                              nxt = r_ok ? R_EXEC : ST_ILLEGAL;
        else if (opcode == OP_J || opcode == OP_JAL)          nxt = JUMP;
        else if (opcode == OP_BEQ || opcode == OP_BNE)        nxt = BRANCH;
        else if (i_ok)                                        nxt = I_EXEC;
        else                                                  nxt = ST_ILLEGAL;
      end
      MEM_ADDR: begin
        alu_src_a   = 1'b1;
        alu_src_b   = 3'b010;
        alu_control = ALU_ADD;
        nxt         = (opcode == OP_SW) ? MEM_WR : MEM_RD;
      end
      MEM_RD: begin
        mem_read = 1'b1;
        iord     = 1'b1;
        if (mem_ready) nxt = MEM_WB;
      end
      MEM_WB: begin
        reg_write = 1'b1;
        mem2reg   = 2'b01;
        nxt       = FETCH;
      end
      MEM_WR: begin
        mem_write = 1'b1;
        iord      = 1'b1;
        if (mem_ready) nxt = FETCH;
      end
      R_EXEC, R_WB: begin
        alu_src_a   = 1'b1;
        alu_control = r_alu;
        if (cur == R_WB) begin
          reg_write = 1'b1;
          reg_dst   = 2'b01;
          nxt       = FETCH;
        end else begin
          nxt = R_WB;
        end
      end
      BRANCH: begin
        alu_src_a    = 1'b1;
        alu_control  = ALU_SUB;
        pc_src       = 2'b01;
        pc_write_beq = (opcode == OP_BEQ);
        pc_write_bne = (opcode == OP_BNE);
        nxt          = FETCH;
      end
      JUMP: begin
        pc_write = 1'b1;
        if (opcode == OP_R) begin
          pc_src = 2'b11;
        end else begin
          pc_src = 2'b10;
          if (opcode == OP_JAL) begin
            // PC already holds PC+4 from FETCH, so it is the link value
            reg_write = 1'b1;
            reg_dst   = 2'b10;
            mem2reg   = 2'b10;
          end
        end
        nxt = FETCH;
      end
      I_EXEC, I_WB: begin
        alu_src_a   = 1'b1;
        alu_src_b   = i_asb;
        alu_control = i_alu;
        if (cur == I_WB) begin
          reg_write = 1'b1;
          nxt       = FETCH;
        end else begin
          nxt = I_WB;
        end
      end
      ST_ILLEGAL: begin
        illegal = 1'b1;
        nxt     = ST_ILLEGAL;
      end
      default: nxt = FETCH;
    endcase
    if (reset) begin
      pc_write     = 1'b0;
      pc_write_beq = 1'b0;
      pc_write_bne = 1'b0;
      ir_write     = 1'b0;
      mem_read     = 1'b0;
      mem_write    = 1'b0;
      reg_write    = 1'b0;
    end
  end

  assign retire = (cur == MEM_WB) || (cur == MEM_WR && mem_ready) || (cur == R_WB) ||
                  (cur == BRANCH) || (cur == JUMP) || (cur == I_WB);

  // Retired-instruction counter, wraps naturally
  always_ff @(posedge clk_cpu) begin
    if (reset)       inst_count <= '0;
    else if (retire) inst_count <= inst_count + CNT_W'(1);
  end

  assign waiting   = (cur == FETCH) || (cur == MEM_RD) || (cur == MEM_WR);
  assign stall_inc = (stall == STALL_MAX) ? stall : stall + SW_W'(1);

  // Memory stall watchdog: saturating consecutive-wait count, sticky timeout
  always_ff @(posedge clk_cpu) begin
    if (reset) begin
      stall       <= '0;
      mem_timeout <= 1'b0;
    end else if (waiting && !mem_ready) begin
      stall <= stall_inc;
      if (stall_inc == STALL_MAX) mem_timeout <= 1'b1;
    end else begin
      stall <= '0;
    end
  end

endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard bench for multicycle_control: stimulus pushes hand-computed
// per-cycle expectations, a negedge monitor pops and compares.
module tb_multicycle_control;

  logic        clk_cpu = 1'b0;
  logic        reset;
  logic [5:0]  opcode, func;
  logic        mem_ready;
  logic        pc_write, pc_write_beq, pc_write_bne, iord, mem_read, mem_write;
  logic        ir_write, reg_write, alu_src_a, illegal, mem_timeout;
  logic [1:0]  pc_src, reg_dst, mem2reg;
  logic [2:0]  alu_src_b, alu_control;
  logic [3:0]  state;
  logic [31:0] inst_count;

  multicycle_control #(.MEM_WAIT_MAX(15), .CNT_W(32)) dut (
    .clk_cpu(clk_cpu), .reset(reset), .opcode(opcode), .func(func),
    .mem_ready(mem_ready), .pc_write(pc_write), .pc_write_beq(pc_write_beq),
    .pc_write_bne(pc_write_bne), .pc_src(pc_src), .iord(iord),
    .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
    .reg_write(reg_write), .reg_dst(reg_dst), .mem2reg(mem2reg),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_control(alu_control),
    .illegal(illegal), .mem_timeout(mem_timeout), .state(state),
    .inst_count(inst_count)
  );

  always #5 clk_cpu = ~clk_cpu;

  localparam logic [2:0] ADD = 3'b010, SUB = 3'b110, AOR = 3'b001;

  typedef struct packed {
    logic [15:0] id;
    logic [3:0]  st;
    logic [22:0] c;
    logic [31:0] n;
  } exp_t;

  exp_t sbq[$];
  int   checks = 0;
  int   errors = 0;
  int   step_id = 0;

  wire [22:0] act_c = {pc_write, pc_write_beq, pc_write_bne, pc_src, iord, mem_read,
                       mem_write, ir_write, reg_write, reg_dst, mem2reg, alu_src_a,
                       alu_src_b, alu_control, illegal, mem_timeout};

  function automatic logic [22:0] mk(input logic pcw, input logic beq, input logic bne,
      input logic [1:0] psrc, input logic io, input logic mr, input logic mw,
      input logic irw, input logic rw, input logic [1:0] rd, input logic [1:0] m2r,
      input logic asa, input logic [2:0] asb, input logic [2:0] alu,
      input logic ill, input logic to);
    return {pcw, beq, bne, psrc, io, mr, mw, irw, rw, rd, m2r, asa, asb, alu, ill, to};
  endfunction

  function automatic logic [22:0] c_fetch(input logic rdy, input logic to);
    return mk(rdy,0,0,2'b00,0,1,0,rdy,0,2'b00,2'b00,0,3'b001,ADD,0,to);
  endfunction

  function automatic logic [22:0] c_dec(input logic to);
    return mk(0,0,0,2'b00,0,0,0,0,0,2'b00,2'b00,0,3'b011,ADD,0,to);
  endfunction

  // One clock of stimulus with its expected observation
  task automatic step(input logic r, input logic [5:0] op, input logic [5:0] fn,
                      input logic rdy, input logic [3:0] st, input logic [22:0] c,
                      input logic [31:0] n);
    exp_t e;
    reset = r; opcode = op; func = fn; mem_ready = rdy;
    step_id++;
    e.id = 16'(step_id); e.st = st; e.c = c; e.n = n;
    sbq.push_back(e);
    @(posedge clk_cpu); #1;
  endtask

  // Monitor: compare DUT outputs against the next expectation mid-cycle
  always @(negedge clk_cpu) begin
    if (sbq.size() > 0) begin
      exp_t e;
      e = sbq.pop_front();
      checks++;
      if (state !== e.st || act_c !== e.c || inst_count !== e.n) begin
        errors++;
        $display("FAIL step%0d: got state=%0d ctrl=%h count=%0d, want state=%0d ctrl=%h count=%0d",
                 e.id, state, act_c, inst_count, e.st, e.c, e.n);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1; opcode = '0; func = '0; mem_ready = 1'b1;
    @(posedge clk_cpu); #1;
    // reset state: FETCH with strobes masked
    step(1, 6'd0, 6'd0, 1, 4'd0, mk(0,0,0,2'b00,0,0,0,0,0,2'b00,2'b00,0,3'b001,ADD,0,0), 0);

    // add: 0,1,6,7
    step(0, 6'b000000, 6'b100000, 1, 4'd0, c_fetch(1,0), 0);
    step(0, 6'b000000, 6'b100000, 1, 4'd1, c_dec(0), 0);
    step(0, 6'b000000, 6'b100000, 1, 4'd6, mk(0,0,0,2'b00,0,0,0,0,0,2'b00,2'b00,1,3'b000,ADD,0,0), 0);
    step(0, 6'b000000, 6'b100000, 1, 4'd7, mk(0,0,0,2'b00,0,0,0,0,1,2'b01,2'b00,1,3'b000,ADD,0,0), 0);

    // lw with three wait cycles in MEM_RD
    step(0, 6'b100011, 6'd0, 1, 4'd0, c_fetch(1,0), 1);
    step(0, 6'b100011, 6'd0, 1, 4'd1, c_dec(0), 1);
    step(0, 6'b100011, 6'd0, 1, 4'd2, mk(0,0,0,2'b00,0,0,0,0,0,2'b00,2'b00,1,3'b010,ADD,0,0), 1);
    for (int i = 0; i < 3; i++)
      step(0, 6'b100011, 6'd0, 0, 4'd3, mk(0,0,0,2'b00,1,1,0,0,0,2'b00,2'b00,0,3'b000,3'b000,0,0), 1);
    step(0, 6'b100011, 6'd0, 1, 4'd3, mk(0,0,0,2'b00,1,1,0,0,0,2'b00,2'b00,0,3'b000,3'b000,0,0), 1);
    step(0, 6'b100011, 6'd0, 1, 4'd4, mk(0,0,0,2'b00,0,0,0,0,1,2'b00,2'b01,0,3'b000,3'b000,0,0), 1);

    // beq then jal
    step(0, 6'b000100, 6'd0, 1, 4'd0, c_fetch(1,0), 2);
    step(0, 6'b000100, 6'd0, 1, 4'd1, c_dec(0), 2);
    step(0, 6'b000100, 6'd0, 1, 4'd8, mk(0,1,0,2'b01,0,0,0,0,0,2'b00,2'b00,1,3'b000,SUB,0,0), 2);
    step(0, 6'b000011, 6'd0, 1, 4'd0, c_fetch(1,0), 3);
    step(0, 6'b000011, 6'd0, 1, 4'd1, c_dec(0), 3);
    step(0, 6'b000011, 6'd0, 1, 4'd9, mk(1,0,0,2'b10,0,0,0,0,1,2'b10,2'b10,0,3'b000,3'b000,0,0), 3);

    // sw with one wait cycle in MEM_WR
    step(0, 6'b101011, 6'd0, 1, 4'd0, c_fetch(1,0), 4);
    step(0, 6'b101011, 6'd0, 1, 4'd1, c_dec(0), 4);
    step(0, 6'b101011, 6'd0, 1, 4'd2, mk(0,0,0,2'b00,0,0,0,0,0,2'b00,2'b00,1,3'b010,ADD,0,0), 4);
    step(0, 6'b101011, 6'd0, 0, 4'd5, mk(0,0,0,2'b00,1,0,1,0,0,2'b00,2'b00,0,3'b000,3'b000,0,0), 4);
    step(0, 6'b101011, 6'd0, 1, 4'd5, mk(0,0,0,2'b00,1,0,1,0,0,2'b00,2'b00,0,3'b000,3'b000,0,0), 4);

    // lui: imm<<16 OR r0
    step(0, 6'b001111, 6'd0, 1, 4'd0, c_fetch(1,0), 5);
    step(0, 6'b001111, 6'd0, 1, 4'd1, c_dec(0), 5);
    step(0, 6'b001111, 6'd0, 1, 4'd10, mk(0,0,0,2'b00,0,0,0,0,0,2'b00,2'b00,1,3'b101,AOR,0,0), 5);
    step(0, 6'b001111, 6'd0, 1, 4'd11, mk(0,0,0,2'b00,0,0,0,0,1,2'b00,2'b00,1,3'b101,AOR,0,0), 5);

    // illegal opcode: sticky until reset
    step(0, 6'b111111, 6'd0, 1, 4'd0, c_fetch(1,0), 6);
    step(0, 6'b111111, 6'd0, 1, 4'd1, c_dec(0), 6);
    for (int i = 0; i < 20; i++)
      step(0, 6'b111111, 6'd0, 1, 4'd12, mk(0,0,0,2'b00,0,0,0,0,0,2'b00,2'b00,0,3'b000,3'b000,1,0), 6);
    step(1, 6'b111111, 6'd0, 1, 4'd12, mk(0,0,0,2'b00,0,0,0,0,0,2'b00,2'b00,0,3'b000,3'b000,1,0), 6);

    // 15 fetch stalls -> timeout visible on the 16th cycle
    for (int i = 0; i < 15; i++)
      step(0, 6'b000000, 6'b100010, 0, 4'd0, c_fetch(0,0), 0);
    step(0, 6'b000000, 6'b100010, 1, 4'd0, c_fetch(1,1), 0);
    step(0, 6'b000000, 6'b100010, 1, 4'd1, c_dec(1), 0);
    step(0, 6'b000000, 6'b100010, 1, 4'd6, mk(0,0,0,2'b00,0,0,0,0,0,2'b00,2'b00,1,3'b000,SUB,0,1), 0);
    step(0, 6'b000000, 6'b100010, 1, 4'd7, mk(0,0,0,2'b00,0,0,0,0,1,2'b01,2'b00,1,3'b000,SUB,0,1), 0);

    // or, with reset pulsed during R_WB
    step(0, 6'b000000, 6'b100101, 1, 4'd0, c_fetch(1,1), 1);
    step(0, 6'b000000, 6'b100101, 1, 4'd1, c_dec(1), 1);
    step(0, 6'b000000, 6'b100101, 1, 4'd6, mk(0,0,0,2'b00,0,0,0,0,0,2'b00,2'b00,1,3'b000,AOR,0,1), 1);
    step(1, 6'b000000, 6'b100101, 1, 4'd7, mk(0,0,0,2'b00,0,0,0,0,0,2'b01,2'b00,1,3'b000,AOR,0,1), 1);
    step(0, 6'b000000, 6'b100101, 1, 4'd0, c_fetch(1,0), 0);
    step(0, 6'b000000, 6'b100101, 1, 4'd1, c_dec(0), 0);

    @(negedge clk_cpu); #1;
    if (sbq.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, want 0", sbq.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
